bch_dec_corr_pipe: RTL



---
 rtl/bch_dec_corr_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bch_dec_corr_pipe.sv
// rtl/bch_dec_corr_pipe.sv - two-stage registered DEC BCH decode/correct stage with saturating event counters
// Optional error-injection ports are enabled by defining BCH_DEC_ERR_INJ_EN.
module bch_dec_corr_pipe #(
  parameter int  P_D_WIDTH   = 32,
  parameter int  P_CNT_WIDTH = 16,
  localparam int GF_M = (P_D_WIDTH <= 7)   ? 4 :
                        (P_D_WIDTH <= 21)  ? 5 :
                        (P_D_WIDTH <= 51)  ? 6 :
                        (P_D_WIDTH <= 113) ? 7 :
                        (P_D_WIDTH <= 239) ? 8 :
                        (P_D_WIDTH <= 493) ? 9 : 10,
  localparam int EW = 2 * GF_M
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_vld_i,
  output logic                       in_rdy_o,
  input  logic [P_D_WIDTH-1:0]       d_i,
  input  logic [EW-1:0]              ecc_i,
`ifdef BCH_DEC_ERR_INJ_EN
  input  logic                       inj_en_i,
  input  logic [P_D_WIDTH+EW-1:0]    inj_msk_i,
`endif
  output logic                       out_vld_o,
  input  logic                       out_rdy_i,
  output logic [P_D_WIDTH-1:0]       d_o,
  output logic                       err_det_o,
  output logic [1:0]                 err_nbits_o,
  output logic                       err_unc_o,
  input  logic                       cnt_clr_i,
  output logic [P_CNT_WIDTH-1:0]     cor_cnt_o,
  output logic [P_CNT_WIDTH-1:0]     unc_cnt_o
);

  localparam int N_CW = P_D_WIDTH + EW;

  // Low-order taps of the primitive polynomial defining GF(2^m).
  function automatic int fn_poly(input int m);
    case (m)
      4:       fn_poly = 'h3;
      5:       fn_poly = 'h5;
      6:       fn_poly = 'h3;
      7:       fn_poly = 'h3;
      8:       fn_poly = 'h1D;
      9:       fn_poly = 'h11;
      default: fn_poly = 'h9;
    endcase
  endfunction

  localparam logic [GF_M-1:0] GF_POLY = GF_M'(fn_poly(GF_M));

  function automatic logic [GF_M-1:0] gf_mul_a(input logic [GF_M-1:0] x);
    logic [GF_M-1:0] sh;
    sh = {x[GF_M-2:0], 1'b0};
    return x[GF_M-1] ? (sh ^ GF_POLY) : sh;
  endfunction

  // Column j of the parity-check matrix is {alpha^(3j), alpha^j}; ecc sits at bits 0..EW-1.
  function automatic logic [N_CW*EW-1:0] fn_h_tab();
    logic [GF_M-1:0]    a1;
    logic [GF_M-1:0]    a3;
    logic [N_CW*EW-1:0] t;
    a1 = GF_M'(1);
    a3 = GF_M'(1);
    t  = '0;
    for (int j = 0; j < N_CW; j++) begin
      t[j*EW +: EW] = {a3, a1};
      a1 = gf_mul_a(a1);
      a3 = gf_mul_a(gf_mul_a(gf_mul_a(a3)));
    end
    return t;
  endfunction

  localparam logic [N_CW*EW-1:0] H_TAB = fn_h_tab();

  logic [N_CW-1:0]      in_cw;
  logic [EW-1:0]        in_synd;
  logic                 s1_vld;
  logic [P_D_WIDTH-1:0] s1_d;
  logic [EW-1:0]        s1_synd;
  logic [P_D_WIDTH-1:0] err_msk;
  logic [1:0]           err_cnt;
  logic                 err_det_nxt;
  logic                 err_unc_nxt;
  logic                 en1;
  logic                 en2;
  logic                 out_hs;

`ifdef BCH_DEC_ERR_INJ_EN
  assign in_cw = {d_i, ecc_i} ^ (inj_en_i ? inj_msk_i : '0);
`else
  assign in_cw = {d_i, ecc_i};
`endif

  always_comb begin
    in_synd = '0;
    for (int j = 0; j < N_CW; j++) begin
      if (in_cw[j]) in_synd = in_synd ^ H_TAB[j*EW +: EW];
    end
  end

  // Syndrome-to-pattern lookup over all data-only weight-1 and weight-2 errors; distance 5 keeps matches unique.
  always_comb begin
    err_msk = '0;
    for (int i = 0; i < P_D_WIDTH; i++) begin
      if (s1_synd == H_TAB[(EW+i)*EW +: EW]) err_msk[i] = 1'b1;
      for (int k = i + 1; k < P_D_WIDTH; k++) begin
        if (s1_synd == (H_TAB[(EW+i)*EW +: EW] ^ H_TAB[(EW+k)*EW +: EW])) begin
          err_msk[i] = 1'b1;
          err_msk[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < P_D_WIDTH; i++) begin
      err_cnt = err_cnt + {1'b0, err_msk[i]};
    end
  end

  assign err_det_nxt = |s1_synd;
  assign err_unc_nxt = err_det_nxt & (err_msk == '0);

  assign en2      = ~out_vld_o | out_rdy_i;
  assign en1      = ~s1_vld | en2;
  assign in_rdy_o = en1;
  assign out_hs   = out_vld_o & out_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld      <= 1'b0;
      s1_d        <= '0;
      s1_synd     <= '0;
      out_vld_o   <= 1'b0;
      d_o         <= '0;
      err_det_o   <= 1'b0;
      err_nbits_o <= 2'd0;
      err_unc_o   <= 1'b0;
      cor_cnt_o   <= '0;
      unc_cnt_o   <= '0;
    end else begin
      if (en1) begin
        s1_vld  <= in_vld_i;
        s1_d    <= in_cw[N_CW-1:EW];
        s1_synd <= in_synd;
      end
      if (en2) begin
        out_vld_o   <= s1_vld;
        d_o         <= s1_d ^ err_msk;
        err_det_o   <= err_det_nxt;
        err_nbits_o <= err_cnt;
        err_unc_o   <= err_unc_nxt;
      end
      // Clear wins over a same-cycle increment; counting only on handshake counts each word once.
      if (cnt_clr_i) begin
        cor_cnt_o <= '0;
        unc_cnt_o <= '0;
      end else if (out_hs) begin
        if ((err_nbits_o != 2'd0) && (cor_cnt_o != '1)) cor_cnt_o <= cor_cnt_o + P_CNT_WIDTH'(1);
        if (err_unc_o && (unc_cnt_o != '1)) unc_cnt_o <= unc_cnt_o + P_CNT_WIDTH'(1);
      end
    end
  end

endmodule
